mem_resp_ctlr: RTL and testbench

// Memory-side responder for the cache/controller bus: accepts BUS_LOAD/BUS_STORE, answers same-cycle with a

---
 rtl/mem_resp_ctlr_pkg.sv | 26 ++
 rtl/mem_resp_fifo.sv | 53 +++++
 rtl/mem_resp_ctlr.sv | 87 ++++++++
 tb/tb_mem_resp_ctlr.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_ctlr_pkg.sv
// Shared bus command encoding and in-flight entry layout for the memory responder.
package mem_resp_ctlr_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } BUS_COMMAND;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_load;
    logic [63:0]      data;
    logic [CNT_W-1:0] countdown;
  } MEM_RESP_ENTRY;

  // Tag 0 means "no response", so the sequence runs 1..15 and wraps back to 1.
  function automatic logic [TAG_W-1:0] next_tag_f(input logic [TAG_W-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Ring buffer of in-flight transactions; every entry's countdown ticks down each cycle.
module mem_resp_fifo
  import mem_resp_ctlr_pkg::*;
#(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  MEM_RESP_ENTRY push_entry,
  input  logic          pop,
  output MEM_RESP_ENTRY head_entry,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  MEM_RESP_ENTRY ent [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_entry = ent[head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      // Stale slots also tick down; harmless since they are overwritten on push.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent[i].countdown != '0) ent[i].countdown <= ent[i].countdown - 1'b1;
      end
      if (push) begin
        ent[tail] <= push_entry;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_resp_ctlr.sv
// Memory-side bus responder: tags requests on acceptance, completes them in order after LATENCY cycles.
module mem_resp_ctlr
  import mem_resp_ctlr_pkg::*;
#(
  parameter int unsigned LATENCY   = 10,
  parameter int unsigned MAX_INFL  = 15,
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  input  logic            mem_stall,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_INFL + 1);

  logic [63:0]      mem [MEM_WORDS];
  logic [IW-1:0]    idx;
  BUS_COMMAND       cmd;
  logic             is_load;
  logic             is_store;
  logic             accept;
  logic             completing;
  logic [TAG_W-1:0] next_tag;
  logic [CW-1:0]    count;
  MEM_RESP_ENTRY    push_entry;
  MEM_RESP_ENTRY    head_entry;
  logic             unused_addr;

  assign idx         = proc2mem_addr[3 +: IW];
  assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IW]};
  assign cmd         = BUS_COMMAND'(proc2mem_command);
  assign is_load     = (cmd == BUS_LOAD);
  assign is_store    = (cmd == BUS_STORE);

  // A full queue still admits a request when the head retires on the same edge.
  assign completing = (count != '0) && (head_entry.countdown == '0);
  assign accept     = (is_load || is_store) && !mem_stall &&
                      ((count < CW'(MAX_INFL)) || completing);

  assign mem2proc_response = accept ? next_tag : '0;

  always_comb begin
    push_entry           = '0;
    push_entry.tag       = next_tag;
    push_entry.is_load   = is_load;
    push_entry.data      = is_load ? mem[idx] : '0;
    push_entry.countdown = CNT_W'(LATENCY - 1);
  end

  mem_resp_fifo #(
    .DEPTH (MAX_INFL),
    .CW    (CW)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (completing),
    .head_entry (head_entry),
    .count      (count)
  );

  // Backing store survives reset so preloaded contents remain valid.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem[idx] <= proc2mem_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next_tag      <= 4'd1;
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
    end else begin
      if (accept) next_tag <= next_tag_f(next_tag);
      mem2proc_tag  <= completing ? head_entry.tag : '0;
      mem2proc_data <= (completing && head_entry.is_load) ? head_entry.data : '0;
    end
  end

endmodule

// File: tb/tb_mem_resp_ctlr.sv
// Scoreboard bench for mem_resp_ctlr: expected completions queued on acceptance, checked every cycle.
module tb_mem_resp_ctlr;
  import mem_resp_ctlr_pkg::*;

  localparam int LAT  = 20;
  localparam int INFL = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  proc2mem_command = 2'b00;
  logic [31:0] proc2mem_addr = '0;
  logic [63:0] proc2mem_data = '0;
  logic        mem_stall = 1'b0;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mmem [int];
  logic [3:0]  mtag = 4'd1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_resp_ctlr #(
    .LATENCY   (LAT),
    .MAX_INFL  (INFL),
    .MEM_WORDS (8192)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem_stall         (mem_stall),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: tag/data must match the queue head exactly on its due cycle, else be zero.
  initial forever begin
    @(posedge clock);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("cmp_tag", {60'd0, mem2proc_tag}, {60'd0, sb[0].tag});
      chk("cmp_data", mem2proc_data, sb[0].data);
      void'(sb.pop_front());
    end else begin
      chk("idle_tag", {60'd0, mem2proc_tag}, 64'd0);
      chk("idle_data", mem2proc_data, 64'd0);
    end
  end

  // Drive one cycle of request from a negedge, check the combinational response, advance to next negedge.
  task automatic step(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                      input logic stall, output logic [3:0] resp);
    logic        comp;
    logic        acc;
    int          idx;
    logic [63:0] ld;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = data;
    mem_stall        = stall;
    #1;
    comp = (sb.size() > 0) && (sb[0].due == cyc + 1);
    acc  = (cmd == BUS_LOAD || cmd == BUS_STORE) && !stall && (sb.size() < INFL || comp);
    resp = mem2proc_response;
    chk("resp", {60'd0, resp}, acc ? {60'd0, mtag} : 64'd0);
    if (acc) begin
      idx = int'(addr[15:3]);
      if (cmd == BUS_STORE) begin
        mmem[idx] = data;
        ld = '0;
      end else begin
        ld = mmem.exists(idx) ? mmem[idx] : 64'd0;
      end
      sb.push_back('{due: cyc + 1 + LAT, tag: mtag, data: ld});
      mtag = (mtag == 4'd15) ? 4'd1 : mtag + 4'd1;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    logic [3:0] r;
    for (int i = 0; i < n; i++) step(BUS_NONE, 32'd0, 64'd0, 1'b0, r);
  endtask

  task automatic do_reset();
    proc2mem_command = BUS_NONE;
    mem_stall        = 1'b0;
    reset            = 1'b0;
    sb.delete();
    mtag = 4'd1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    int         refused;
    #1;
    do_reset();
    chk("rst_tag", {60'd0, mem2proc_tag}, 64'd0);
    chk("rst_data", mem2proc_data, 64'd0);
    chk("rst_resp", {60'd0, mem2proc_response}, 64'd0);

    // Preload, then reset: the line must survive the reset.
    step(BUS_STORE, 32'h100, 64'hDEAD_BEEF_0123_4567, 1'b0, r);
    idle(LAT + 2);

    // Single load with exact completion timing
    do_reset();
    step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
    chk("s1_resp", {60'd0, r}, 64'd1);
    idle(LAT - 1);
    chk("s1_early_tag", {60'd0, mem2proc_tag}, 64'd0);
    idle(1);
    chk("s1_tag", {60'd0, mem2proc_tag}, 64'd1);
    chk("s1_data", mem2proc_data, 64'hDEAD_BEEF_0123_4567);
    idle(1);
    chk("s1_tag_after", {60'd0, mem2proc_tag}, 64'd0);
    chk("s1_data_after", mem2proc_data, 64'd0);

    // Store then load same line
    do_reset();
    step(BUS_STORE, 32'h200, 64'hA5A5, 1'b0, r);
    chk("s2_st_resp", {60'd0, r}, 64'd1);
    step(BUS_LOAD, 32'h200, 64'd0, 1'b0, r);
    chk("s2_ld_resp", {60'd0, r}, 64'd2);
    idle(LAT - 2);
    idle(1);
    chk("s2_st_tag", {60'd0, mem2proc_tag}, 64'd1);
    chk("s2_st_data", mem2proc_data, 64'd0);
    idle(1);
    chk("s2_ld_tag", {60'd0, mem2proc_tag}, 64'd2);
    chk("s2_ld_data", mem2proc_data, 64'hA5A5);
    idle(3);

    // Fill all 15 tags, 16th refused until the head retires, then wraps to tag 1
    do_reset();
    for (int i = 0; i < INFL; i++) begin
      step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
      chk("s3_fill_resp", {60'd0, r}, 64'(i + 1));
    end
    refused = 0;
    for (int k = 0; k < 100; k++) begin
      step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
      if (r != 4'd0) break;
      refused++;
    end
    chk("s3_retry_tag", {60'd0, r}, 64'd1);
    chk("s3_refused", 64'(refused), 64'(LAT - INFL));
    idle(LAT + 2);

    // Backpressure
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(BUS_LOAD, 32'h100, 64'd0, 1'b1, r);
      chk("s4_stall_resp", {60'd0, r}, 64'd0);
    end
    step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
    chk("s4_release_resp", {60'd0, r}, 64'd1);
    idle(LAT + 2);

    // Address aliasing and illegal command
    step(BUS_STORE, 32'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, r);
    step(BUS_LOAD, 32'h0001_0000, 64'd0, 1'b0, r);
    idle(LAT);
    chk("s5_alias_data", mem2proc_data, 64'h1234_5678_9ABC_DEF0);
    step(2'b11, 32'h100, 64'd0, 1'b0, r);
    chk("s5_illegal_resp", {60'd0, r}, 64'd0);
    idle(2);

    // Reset with a load in flight: it must never complete
    step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
    idle(2);
    do_reset();
    idle(LAT + 5);
    step(BUS_LOAD, 32'h100, 64'd0, 1'b0, r);
    chk("s6_next_tag", {60'd0, r}, 64'd1);

    idle(LAT + 3);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
